// File: rtl/dbg_mem_reader.sv
// Debug memory read-back: holds the CPU in reset, reads word_cnt words over the debug port
// and streams them LSB-first on a valid/ready byte stream. Optional trailing sum byte: DBG_RD_CHECKSUM_EN.
module dbg_mem_reader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      start_adr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             cpu_n_reset,
  output logic             dbg_mem_op,
  output logic [3:0]       dbg_wren,
  output logic [31:0]      dbg_adr,
  input  logic [31:0]      dbg_di,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAP, SEND, NEXT, FIN, CSUM} state_t;

`ifdef DBG_RD_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = FIN;
`endif

  state_t           state, state_nxt;
  logic [31:0]      adr;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       wait_cnt;
  logic [31:0]      shift;
  logic [1:0]       byte_idx;
  logic [7:0]       sum;
  logic             hs;
  logic             adr_lo_unused;

  // Address is always word-aligned, so the low start address bits are dropped.
  assign adr_lo_unused = ^start_adr[1:0];
  assign hs            = tx_valid && tx_ready;
  assign dbg_wren      = 4'h0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    dbg_mem_op  = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (state)
      IDLE: if (start) state_nxt = (word_cnt != '0) ? REQ : END_ST;
      REQ:  begin busy = 1'b1; dbg_mem_op = 1'b1; state_nxt = WAIT; end
      WAIT: begin
        busy = 1'b1; dbg_mem_op = 1'b1;
        if (wait_cnt == 3'd0) state_nxt = CAP;
      end
      CAP:  begin busy = 1'b1; dbg_mem_op = 1'b1; state_nxt = SEND; end
      SEND: begin
        busy = 1'b1; dbg_mem_op = 1'b1;
        tx_valid = 1'b1; tx_data = shift[7:0];
        if (hs && byte_idx == 2'd3) state_nxt = NEXT;
      end
      NEXT: begin
        busy = 1'b1; dbg_mem_op = 1'b1;
        state_nxt = (remaining != CNT_W'(1)) ? REQ : END_ST;
      end
      FIN:  begin done = 1'b1; state_nxt = IDLE; end
      CSUM: begin
        busy = 1'b1; tx_valid = 1'b1; tx_data = sum;
        if (hs) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_n_reset = ~busy;
  assign dbg_adr     = dbg_mem_op ? adr : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      adr       <= 32'h0;
      remaining <= '0;
      wait_cnt  <= 3'd0;
      shift     <= 32'h0;
      byte_idx  <= 2'd0;
      sum       <= 8'h00;
    end else begin
      case (state)
        IDLE: if (start) begin
          adr       <= {start_adr[31:2], 2'b00};
          remaining <= word_cnt;
          sum       <= 8'h00;
        end
        REQ:  wait_cnt <= 3'(RD_LAT - 1);
        WAIT: if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        CAP:  begin shift <= dbg_di; byte_idx <= 2'd0; end
        SEND: if (hs) begin
          shift    <= {8'h00, shift[31:8]};
          byte_idx <= byte_idx + 2'd1;
`ifdef DBG_RD_CHECKSUM_EN
          sum      <= sum + shift[7:0];
`endif
        end
        NEXT: begin
          remaining <= remaining - CNT_W'(1);
          adr       <= adr + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule
